// File: rtl/cram_dual_bank.sv
// Dual-bank CPU RAM with a per-bank write FSM and a shared video read port.
// Define CRAM_WR_BYPASS_EN to forward same-cycle CPU write data to the video port.
module cram_dual_bank #(
  parameter int AW      = 9,
  parameter int DW      = 8,
  parameter int VID_LAT = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [AW-1:0]   ADDR,
  input  logic            CEn,
  input  logic            OE1n,
  input  logic            OE2n,
  input  logic            WE1n,
  input  logic            WE2n,
  input  logic [DW-1:0]   DIN,
  output logic [DW-1:0]   DOUT1,
  output logic [DW-1:0]   DOUT2,
  output logic            DOE1,
  output logic            DOE2,
  input  logic [AW-1:0]   VADDR,
  output logic [2*DW-1:0] VDATA,
  output logic            VVALID
);

  localparam int DEPTH = 2 ** AW;

`ifdef CRAM_WR_BYPASS_EN
  localparam bit WR_BYPASS = 1'b1;
`else
  localparam bit WR_BYPASS = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WRITE, HOLD} wr_state_t;

  logic [1:0]         we_n;
  logic [1:0]         oe_n;
  logic [1:0][DW-1:0] dout_b;
  logic [1:0]         doe_b;
  logic [1:0][DW-1:0] vdata_p0;
  logic               vld_p0;

  assign we_n = {WE2n, WE1n};
  assign oe_n = {OE2n, OE1n};

  function automatic logic [DW-1:0] fwd_byte(input logic [DW-1:0] ram_b,
                                             input logic [DW-1:0] wr_b,
                                             input logic          hit);
    return (WR_BYPASS && hit) ? wr_b : ram_b;
  endfunction

  for (genvar b = 0; b < 2; b++) begin : g_bank
    wr_state_t     state;
    wr_state_t     state_nxt;
    logic          wr_en;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] dout_r;
    logic          doe_r;
    logic [DW-1:0] vbyte_p0;

    always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
    end

    // Write with OE also low is treated as a bus conflict and never starts a write.
    always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      case (state)
        IDLE:    if (!CEn && !we_n[b] && oe_n[b]) state_nxt = WRITE;
        WRITE: begin
          wr_en     = !RST;
          state_nxt = HOLD;
        end
        HOLD:    if (we_n[b] || CEn) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    always_ff @(posedge CLK) begin
      if (wr_en) mem[ADDR] <= DIN;
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        dout_r <= '0;
        doe_r  <= 1'b0;
      end else if (!CEn && !oe_n[b] && we_n[b]) begin
        dout_r <= mem[ADDR];
        doe_r  <= 1'b1;
      end else begin
        doe_r  <= 1'b0;
      end
    end

    // Video stage p0: array read, old data unless forwarding is enabled.
    always_ff @(posedge CLK) begin
      if (RST) vbyte_p0 <= '0;
      else     vbyte_p0 <= fwd_byte(mem[VADDR], DIN, wr_en && (ADDR == VADDR));
    end

    assign dout_b[b]   = dout_r;
    assign doe_b[b]    = doe_r;
    assign vdata_p0[b] = vbyte_p0;
  end

  always_ff @(posedge CLK) begin
    if (RST) vld_p0 <= 1'b0;
    else     vld_p0 <= 1'b1;
  end

  assign DOUT1 = dout_b[0];
  assign DOUT2 = dout_b[1];
  assign DOE1  = doe_b[0];
  assign DOE2  = doe_b[1];

  if (VID_LAT == 1) begin : g_lat1
    assign VDATA  = vdata_p0;
    assign VVALID = vld_p0;
  end else begin : g_lat2
    logic [2*DW-1:0] vdata_p1;
    logic            vld_p1;

    // Video stage p1: output register.
    always_ff @(posedge CLK) begin
      if (RST) begin
        vdata_p1 <= '0;
        vld_p1   <= 1'b0;
      end else begin
        vdata_p1 <= vdata_p0;
        vld_p1   <= vld_p0;
      end
    end

    assign VDATA  = vdata_p1;
    assign VVALID = vld_p1;
  end

endmodule

// File: tb/tb_cram_dual_bank.sv
// Bench for cram_dual_bank: CPU read table, write/reset sequences, video scoreboard.
module tb_cram_dual_bank;
  localparam int VL = 2;

  logic        CLK = 1'b0;
  logic        RST, CEn, OE1n, OE2n, WE1n, WE2n, DOE1, DOE2, VVALID;
  logic [8:0]  ADDR, VADDR;
  logic [7:0]  DIN, DOUT1, DOUT2;
  logic [15:0] VDATA;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [7:0] m1 [512];
  logic [7:0] m2 [512];

  typedef struct {
    logic [15:0] exp;
    int          due;
  } sb_t;
  sb_t sb [$];

  typedef struct {
    logic       cen, oe1n, oe2n;
    logic [8:0] addr;
    logic       edoe1, edoe2;
    logic [7:0] edout1, edout2;
  } rd_vec_t;
  rd_vec_t rv [6];

  cram_dual_bank #(.AW(9), .DW(8), .VID_LAT(VL)) dut (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .CEn(CEn), .OE1n(OE1n), .OE2n(OE2n),
    .WE1n(WE1n), .WE2n(WE2n), .DIN(DIN), .DOUT1(DOUT1), .DOUT2(DOUT2),
    .DOE1(DOE1), .DOE2(DOE2), .VADDR(VADDR), .VDATA(VDATA), .VVALID(VVALID)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic logic [7:0] p1(input logic [8:0] a);
    return a[7:0] ^ (a[8] ? 8'hA5 : 8'h3C);
  endfunction

  function automatic logic [7:0] p2(input logic [8:0] a);
    return (a[7:0] + 8'd17) ^ (a[8] ? 8'h0F : 8'hF0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Video scoreboard: compare each expected word in the cycle it is due.
  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].due == cyc) begin
      sb_t e;
      e = sb.pop_front();
      chk("vdata", {15'd0, VVALID, VDATA}, {15'd0, 1'b1, e.exp});
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic vid_drive(input logic [8:0] a, input logic [15:0] e);
    VADDR = a;
    sb.push_back('{exp: e, due: cyc + VL});
  endtask

  task automatic drain();
    repeat (VL + 1) tick();
  endtask

  task automatic cpu_write(input logic [1:0] mask, input logic [8:0] a,
                           input logic [7:0] d, input int nlow);
    CEn = 1'b0; OE1n = 1'b1; OE2n = 1'b1; ADDR = a; DIN = d;
    WE1n = !mask[0]; WE2n = !mask[1];
    for (int i = 0; i < nlow; i++) begin
      if (i >= 2) DIN = ~d;
      tick();
    end
    WE1n = 1'b1; WE2n = 1'b1; CEn = 1'b1; DIN = d;
    tick();
    if (mask[0]) m1[a] = d;
    if (mask[1]) m2[a] = d;
  endtask

  task automatic rd1(input string name, input logic [8:0] a, input logic [7:0] e);
    CEn = 1'b0; OE1n = 1'b0; WE1n = 1'b1; ADDR = a;
    tick();
    chk({name, "_dout1"}, {24'd0, DOUT1}, {24'd0, e});
    chk({name, "_doe1"}, {31'd0, DOE1}, 32'd1);
    OE1n = 1'b1; CEn = 1'b1;
    tick();
  endtask

  initial begin
    rv[0] = '{1'b0, 1'b0, 1'b0, 9'h002, 1'b1, 1'b1, 8'hAA, 8'h55};
    rv[1] = '{1'b0, 1'b0, 1'b1, 9'h1FE, 1'b1, 1'b0, p1(9'h1FE), 8'h55};
    rv[2] = '{1'b0, 1'b1, 1'b0, 9'h100, 1'b0, 1'b1, p1(9'h1FE), p2(9'h100)};
    rv[3] = '{1'b1, 1'b0, 1'b0, 9'h002, 1'b0, 1'b0, p1(9'h1FE), p2(9'h100)};
    rv[4] = '{1'b0, 1'b1, 1'b1, 9'h0AA, 1'b0, 1'b0, p1(9'h1FE), p2(9'h100)};
    rv[5] = '{1'b0, 1'b0, 1'b0, 9'h155, 1'b1, 1'b1, p1(9'h155), p2(9'h155)};

    RST = 1'b1; CEn = 1'b1; OE1n = 1'b1; OE2n = 1'b1; WE1n = 1'b1; WE2n = 1'b1;
    ADDR = '0; DIN = '0; VADDR = '0;
    repeat (3) tick();
    chk("rst_dout1", {24'd0, DOUT1}, 32'd0);
    chk("rst_dout2", {24'd0, DOUT2}, 32'd0);
    chk("rst_doe", {30'd0, DOE2, DOE1}, 32'd0);
    chk("rst_vdata", {16'd0, VDATA}, 32'd0);
    chk("rst_vvalid", {31'd0, VVALID}, 32'd0);

    RST = 1'b0;
    for (int i = 1; i <= VL; i++) begin
      tick();
      chk("vvalid_rise", {31'd0, VVALID}, {31'd0, (i == VL)});
    end

    for (int a = 0; a < 512; a++) begin
      cpu_write(2'b01, a[8:0], p1(a[8:0]), 2);
      cpu_write(2'b10, a[8:0], p2(a[8:0]), 2);
    end

    // Single write despite WE1n held low for three cycles.
    cpu_write(2'b01, 9'h002, 8'hAA, 3);
    rd1("wr_once", 9'h002, 8'hAA);

    cpu_write(2'b10, 9'h002, 8'h55, 2);
    vid_drive(9'h002, {m2[2], m1[2]});
    tick();
    drain();

    for (int i = 0; i < 6; i++) begin
      CEn = rv[i].cen; OE1n = rv[i].oe1n; OE2n = rv[i].oe2n; ADDR = rv[i].addr;
      WE1n = 1'b1; WE2n = 1'b1;
      tick();
      chk($sformatf("tbl%0d_dout1", i), {24'd0, DOUT1}, {24'd0, rv[i].edout1});
      chk($sformatf("tbl%0d_dout2", i), {24'd0, DOUT2}, {24'd0, rv[i].edout2});
      chk($sformatf("tbl%0d_doe1", i), {31'd0, DOE1}, {31'd0, rv[i].edoe1});
      chk($sformatf("tbl%0d_doe2", i), {31'd0, DOE2}, {31'd0, rv[i].edoe2});
    end
    CEn = 1'b1; OE1n = 1'b1; OE2n = 1'b1;
    tick();

    // WE and OE low together: ignored.
    CEn = 1'b0; ADDR = 9'h002; WE1n = 1'b0; OE1n = 1'b0; DIN = 8'h00;
    repeat (3) tick();
    chk("we_oe_doe1", {31'd0, DOE1}, 32'd0);
    WE1n = 1'b1;
    tick();
    chk("we_oe_dout1", {24'd0, DOUT1}, 32'h0000_00AA);
    OE1n = 1'b1; CEn = 1'b1;
    tick();

    // Same-cycle write/video collision at the top address.
    CEn = 1'b0; ADDR = 9'h1FF; DIN = 8'h11; WE1n = 1'b0; VADDR = 9'h1FE;
    tick();
`ifdef CRAM_WR_BYPASS_EN
    vid_drive(9'h1FF, {m2[9'h1FF], 8'h11});
`else
    vid_drive(9'h1FF, {m2[9'h1FF], m1[9'h1FF]});
`endif
    tick();
    WE1n = 1'b1; CEn = 1'b1; m1[9'h1FF] = 8'h11;
    vid_drive(9'h1FF, {m2[9'h1FF], m1[9'h1FF]});
    tick();
    vid_drive(9'h000, {m2[0], m1[0]});
    tick();
    drain();

    // Reset during HOLD with WE1n still low.
    CEn = 1'b0; ADDR = 9'h010; DIN = 8'h77; WE1n = 1'b0;
    tick();
    tick();
    m1[9'h010] = 8'h77;
    RST = 1'b1; ADDR = 9'h011; DIN = 8'h88;
    tick();
    tick();
    chk("hold_rst_dout1", {24'd0, DOUT1}, 32'd0);
    chk("hold_rst_dout2", {24'd0, DOUT2}, 32'd0);
    chk("hold_rst_doe", {30'd0, DOE2, DOE1}, 32'd0);
    chk("hold_rst_vdata", {16'd0, VDATA}, 32'd0);
    chk("hold_rst_vvalid", {31'd0, VVALID}, 32'd0);
    RST = 1'b0; ADDR = 9'h010; DIN = 8'h99;
    for (int i = 1; i <= VL; i++) begin
      tick();
      chk("hold_rel_vvalid", {31'd0, VVALID}, {31'd0, (i == VL)});
    end
    DIN = 8'hAB;
    tick();
    WE1n = 1'b1; CEn = 1'b1;
    tick();
    m1[9'h010] = 8'h99;
    rd1("rst_rewrite", 9'h010, m1[9'h010]);
    rd1("rst_nowrite", 9'h011, m1[9'h011]);

    for (int a = 0; a < 512; a++) begin
      vid_drive(a[8:0], {m2[a], m1[a]});
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
